// File: rtl/shutdown_sequencer.sv
// Rail power-down sequencer: walks rails off highest index first.
// Optional power-good handshake and fault timeout: SHUTDOWN_PG_CHECK_EN.
module shutdown_sequencer #(
  parameter int CLK_HZ         = 24000000,
  parameter int STAGE_DLY_MS   = 10,
  parameter int ACK_TIMEOUT_MS = 50,
  parameter int NUM_RAILS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 timeout,
  input  logic                 sw_req,
  input  logic [NUM_RAILS-1:0] rail_pg,
  input  logic                 clear,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [1:0]           cause,
  output logic [2:0]           state
);

  localparam int DLY_CNT = (CLK_HZ / 1000) * STAGE_DLY_MS;
  localparam int ACK_CNT = (CLK_HZ / 1000) * ACK_TIMEOUT_MS;
  localparam int CNT_MAX = (DLY_CNT > ACK_CNT) ? DLY_CNT : ACK_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_RAILS);

  localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CNT - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NUM_RAILS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_DISABLE = 3'd2;
  localparam logic [2:0] S_DELAY   = 3'd4;
  localparam logic [2:0] S_OFF     = 3'd5;

`ifdef SHUTDOWN_PG_CHECK_EN
  localparam logic [2:0]    S_WAIT_PG = 3'd3;
  localparam logic [2:0]    S_AFTER_DIS = S_WAIT_PG;
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_CNT - 1);
`else
  localparam logic [2:0]    S_AFTER_DIS = S_DELAY;
`endif

  logic [2:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_cnt;
  logic [NUM_RAILS-1:0] r_rail_en;
  logic                 r_busy;
  logic                 r_done;
  logic [1:0]           r_cause;
  logic                 r_timeout_d;
  logic                 w_trig_wd;

`ifdef SHUTDOWN_PG_CHECK_EN
  logic                 r_fault;
`endif

  assign w_trig_wd = timeout & ~r_timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_rail_en   <= '1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cause     <= 2'b00;
      r_timeout_d <= 1'b0;
`ifdef SHUTDOWN_PG_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      r_timeout_d <= timeout;
      case (r_state)
        S_IDLE: begin
          if (w_trig_wd || sw_req) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
            r_cause <= w_trig_wd ? 2'b01 : 2'b10;
          end
        end
        S_ARM: begin
          r_idx   <= IDX_TOP;
          r_state <= S_DISABLE;
        end
        S_DISABLE: begin
          r_rail_en[r_idx] <= 1'b0;
          r_cnt            <= '0;
          r_state          <= S_AFTER_DIS;
        end
`ifdef SHUTDOWN_PG_CHECK_EN
        S_WAIT_PG: begin
          if (!rail_pg[r_idx]) begin
            r_cnt   <= '0;
            r_state <= S_DELAY;
          end else if (r_cnt == ACK_LAST) begin
            // a stuck rail is flagged but never stalls the sequence
            r_fault <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DELAY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_DELAY: begin
          if (r_cnt == DLY_LAST) begin
            r_cnt <= '0;
            if (r_idx == '0) begin
              r_state <= S_OFF;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= S_DISABLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OFF: begin
          r_rail_en <= '0;
          if (clear) begin
            r_state   <= S_IDLE;
            r_rail_en <= '1;
            r_done    <= 1'b0;
            r_cause   <= 2'b00;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rail_en = r_rail_en;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cause   = r_cause;
  assign state   = r_state;

`ifdef SHUTDOWN_PG_CHECK_EN
  assign fault = r_fault;
`else
  // power-good is not consulted; keep the port read so it is not dangling
  assign fault = 1'b0 & (|rail_pg);
`endif

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Scoreboard bench for shutdown_sequencer.
// Expected rail_en steps are queued at trigger time and matched on change.
module tb_shutdown_sequencer;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] DIS  = 3'd2;
  localparam logic [2:0] DLY  = 3'd4;
  localparam logic [2:0] OFF  = 3'd5;

`ifdef SHUTDOWN_PG_CHECK_EN
  localparam int   S       = 15;
  localparam int   STUCK_S = 31;
  localparam logic EXP_FLT = 1'b1;
`else
  localparam int   S       = 11;
  localparam int   STUCK_S = 11;
  localparam logic EXP_FLT = 1'b0;
`endif

  typedef struct {
    logic [3:0] en;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timeout = 1'b0;
  logic       sw_req = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] rail_pg;
  logic [3:0] rail_en;
  logic       busy, done, fault;
  logic [1:0] cause;
  logic [2:0] state;

  logic [3:0] pg1 = 4'hF, pg2 = 4'hF, pg3 = 4'hF;
  logic [3:0] stuck = 4'h0;
  logic       flt = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];

  logic [11:0] s, e;

  shutdown_sequencer #(
    .CLK_HZ(10000),
    .STAGE_DLY_MS(1),
    .ACK_TIMEOUT_MS(2),
    .NUM_RAILS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .timeout(timeout),
    .sw_req(sw_req),
    .rail_pg(rail_pg),
    .clear(clear),
    .rail_en(rail_en),
    .busy(busy),
    .done(done),
    .fault(fault),
    .cause(cause),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pg1 <= rail_en;
    pg2 <= pg1;
    pg3 <= pg2;
  end

  assign rail_pg = pg3 | stuck;

  function automatic logic [11:0] snap();
    return {rail_en, busy, done, fault, cause, state};
  endfunction

  task automatic push_seq(input int n0, input int s1,
                          input int s2, input int s3);
    ev_t ev;
    ev.en = 4'b0111; ev.cyc = n0 + 3;            q.push_back(ev);
    ev.en = 4'b0011; ev.cyc = n0 + 3 + s1;       q.push_back(ev);
    ev.en = 4'b0001; ev.cyc = n0 + 3 + s1 + s2;  q.push_back(ev);
    ev.en = 4'b0000; ev.cyc = n0 + 3 + s1 + s2 + s3; q.push_back(ev);
  endtask

  task automatic sb_drain(input int budget);
    logic [3:0] prev;
    ev_t ev;
    prev = rail_en;
    for (int i = 0; i < budget && q.size() > 0; i++) begin
      @(negedge clk);
      if (rail_en !== prev) begin
        prev = rail_en;
        ev = q.pop_front();
        checks++;
        if (rail_en !== ev.en || cyc != ev.cyc) begin
          errors++;
          $display("FAIL rail_step: got %b @%0d want %b @%0d",
                   rail_en, cyc, ev.en, ev.cyc);
        end
      end
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL rail_step_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_off();
    int i;
    i = 0;
    while (state !== OFF && i < 200) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (state !== OFF) begin
      errors++;
      $display("FAIL wait_off: got state %0d want %0d", state, OFF);
    end
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    s = snap(); e = {4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, IDLE};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL reset_vals: got %b want %b", s, e);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    s = snap();
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL post_reset_idle: got %b want %b", s, e);
    end
  endtask

  task automatic test_watchdog();
    int n0;
    n0 = cyc;
    timeout = 1'b1;
    push_seq(n0, S, S, S);
    @(negedge clk);
    s = snap(); e = {4'b1111, 1'b1, 1'b0, 1'b0, 2'b01, ARM};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL wd_arm: got %b want %b", s, e);
    end
    @(negedge clk);
    s = snap(); e = {4'b1111, 1'b1, 1'b0, 1'b0, 2'b01, DIS};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL wd_disable: got %b want %b", s, e);
    end
    sb_drain(200);
    repeat (S - 2) @(negedge clk);
    s = snap(); e = {4'b0000, 1'b1, 1'b0, 1'b0, 2'b01, DLY};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL wd_last_delay: got %b want %b", s, e);
    end
    @(negedge clk);
    s = snap(); e = {4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, OFF};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL wd_off: got %b want %b", s, e);
    end
    timeout = 1'b0;
  endtask

  task automatic test_off_clear();
    @(negedge clk);
    timeout = 1'b1;
    sw_req = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
    sw_req = 1'b0;
    @(negedge clk);
    s = snap(); e = {4'b0000, 1'b0, 1'b1, 1'b0, 2'b01, OFF};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL off_ignore: got %b want %b", s, e);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    s = snap(); e = {4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, IDLE};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL off_clear: got %b want %b", s, e);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int n0;
    n0 = cyc;
    timeout = 1'b1;
    sw_req = 1'b1;
    push_seq(n0, S, S, S);
    @(negedge clk);
    sw_req = 1'b0;
    s = snap(); e = {4'b1111, 1'b1, 1'b0, 1'b0, 2'b01, ARM};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL simul_cause: got %b want %b", s, e);
    end
    sb_drain(200);
    wait_off();
    do_clear();
    s = snap(); e = {4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, IDLE};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL held_timeout_no_retrig: got %b want %b", s, e);
    end
    timeout = 1'b0;
    @(negedge clk);
    n0 = cyc;
    sw_req = 1'b1;
    push_seq(n0, S, S, S);
    @(negedge clk);
    sw_req = 1'b0;
    s = snap(); e = {4'b1111, 1'b1, 1'b0, 1'b0, 2'b10, ARM};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL sw_cause: got %b want %b", s, e);
    end
    sb_drain(200);
    wait_off();
    do_clear();
  endtask

  task automatic test_ignore();
    int n0;
    n0 = cyc;
    sw_req = 1'b1;
    push_seq(n0, S, S, S);
    fork
      sb_drain(200);
      begin
        @(negedge clk);
        sw_req = 1'b0;
        repeat (7) @(negedge clk);
        s = snap(); e = {4'b0111, 1'b1, 1'b0, flt, 2'b10, DLY};
        checks++;
        if (s !== e) begin
          errors++; $display("FAIL ign_pre: got %b want %b", s, e);
        end
        timeout = 1'b1;
        sw_req = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
        sw_req = 1'b0;
        clear = 1'b0;
        s = snap();
        checks++;
        if (s !== e) begin
          errors++; $display("FAIL ign_post: got %b want %b", s, e);
        end
      end
    join
    wait_off();
    do_clear();
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = cyc;
    sw_req = 1'b1;
    push_seq(n0, S, S, S);
    sb_drain(200);
    wait_off();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    s = snap(); e = {4'b1111, 1'b0, 1'b0, flt, 2'b00, IDLE};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL b2b_clear: got %b want %b", s, e);
    end
    n0 = cyc;
    push_seq(n0, S, S, S);
    @(negedge clk);
    sw_req = 1'b0;
    s = snap(); e = {4'b1111, 1'b1, 1'b0, flt, 2'b10, ARM};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL b2b_rearm: got %b want %b", s, e);
    end
    sb_drain(200);
    wait_off();
    do_clear();
  endtask

  task automatic test_stuck_rail();
    int n0;
    stuck = 4'b0100;
    n0 = cyc;
    sw_req = 1'b1;
    push_seq(n0, S, STUCK_S, S);
    @(negedge clk);
    sw_req = 1'b0;
    sb_drain(300);
    wait_off();
    flt = EXP_FLT;
    s = snap(); e = {4'b0000, 1'b0, 1'b1, flt, 2'b10, OFF};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL stuck_off: got %b want %b", s, e);
    end
    stuck = 4'b0000;
    do_clear();
    s = snap(); e = {4'b1111, 1'b0, 1'b0, flt, 2'b00, IDLE};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL stuck_clear: got %b want %b", s, e);
    end
  endtask

  task automatic test_mid_reset();
    int n0;
    ev_t ev;
    n0 = cyc;
    sw_req = 1'b1;
    ev.en = 4'b0111; ev.cyc = n0 + 3;     q.push_back(ev);
    ev.en = 4'b0011; ev.cyc = n0 + 3 + S; q.push_back(ev);
    @(negedge clk);
    sw_req = 1'b0;
    sb_drain(100);
    #1 rst_n = 1'b0;
    #1;
    s = snap(); e = {4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, IDLE};
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL async_reset: got %b want %b", s, e);
    end
    flt = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    s = snap();
    checks++;
    if (s !== e) begin
      errors++; $display("FAIL reset_release: got %b want %b", s, e);
    end
  endtask

  initial begin
    test_reset();
    test_watchdog();
    test_off_clear();
    test_simultaneous();
    test_ignore();
    test_back_to_back();
    test_stuck_rail();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
